// File: rtl/alu_stage.sv
// ============================================================================
// Module      : alu_stage
// Description : Registered execute stage with a 2-entry skid buffer and a
//               persistent {Z,N,V} status register. Define ALU_CARRY_EN to
//               add carry tracking (out_carry, status_c).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_loads,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic [2:0]       out_flags,
    output logic [2:0]       status
`ifdef ALU_CARRY_EN
    ,
    output logic             out_carry,
    output logic             status_c
`endif
);

    localparam int         c_MSB    = WIDTH - 1;
    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_AND = 2'b10;
    localparam logic [1:0] c_OP_MVN = 2'b11;

    // ------------------------------------------------------------------
    // ALU: result, flags (and carry) of the operation being offered
    // ------------------------------------------------------------------
`ifdef ALU_CARRY_EN
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_carry;
`else
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
`endif
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic [2:0]       w_flags;

    always_comb begin
`ifdef ALU_CARRY_EN
        w_sum   = {1'b0, in_a} + {1'b0, in_b};
        w_diff  = {1'b0, in_a} - {1'b0, in_b};
        w_carry = 1'b0;
`else
        w_sum   = in_a + in_b;
        w_diff  = in_a - in_b;
`endif
        w_res = '0;
        w_ovf = 1'b0;
        case (in_op)
            c_OP_ADD: begin
                w_res = w_sum[c_MSB:0];
                w_ovf = (in_a[c_MSB] == in_b[c_MSB]) && (w_res[c_MSB] != in_a[c_MSB]);
`ifdef ALU_CARRY_EN
                w_carry = w_sum[WIDTH];
`endif
            end
            c_OP_SUB: begin
                w_res = w_diff[c_MSB:0];
                w_ovf = (in_a[c_MSB] != in_b[c_MSB]) && (w_res[c_MSB] != in_a[c_MSB]);
`ifdef ALU_CARRY_EN
                // Carry is the inverted borrow out of the extended subtraction
                w_carry = ~w_diff[WIDTH];
`endif
            end
            c_OP_AND: w_res = in_a & in_b;
            c_OP_MVN: w_res = ~in_b;
            default:  w_res = '0;
        endcase
        w_flags = {(w_res == '0), w_res[c_MSB], w_ovf};
    end

    // ------------------------------------------------------------------
    // Skid buffer: output entry (out_*_q) backed by one skid entry
    // ------------------------------------------------------------------
    logic             out_valid_q;
    logic [WIDTH-1:0] out_c_q;
    logic [2:0]       out_flags_q;
    logic             out_loads_q;
    logic             skid_valid_q;
    logic [WIDTH-1:0] skid_c_q;
    logic [2:0]       skid_flags_q;
    logic             skid_loads_q;
    logic [2:0]       status_q;
`ifdef ALU_CARRY_EN
    logic             out_carry_q;
    logic             skid_carry_q;
    logic             status_c_q;
`endif

    logic w_accept;
    logic w_xfer;

    // in_ready depends only on registered state, never on out_ready
    assign in_ready = ~skid_valid_q;
    assign w_accept = in_valid & ~skid_valid_q;
    assign w_xfer   = out_valid_q & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_c_q      <= '0;
            out_flags_q  <= '0;
            out_loads_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_c_q     <= '0;
            skid_flags_q <= '0;
            skid_loads_q <= 1'b0;
            status_q     <= '0;
`ifdef ALU_CARRY_EN
            out_carry_q  <= 1'b0;
            skid_carry_q <= 1'b0;
            status_c_q   <= 1'b0;
`endif
        end else begin
            if (w_xfer && out_loads_q) begin
                status_q <= out_flags_q;
`ifdef ALU_CARRY_EN
                status_c_q <= out_carry_q;
`endif
            end

            if (w_xfer && skid_valid_q) begin
                // in_ready is low here, so no accept can collide with the move
                out_c_q      <= skid_c_q;
                out_flags_q  <= skid_flags_q;
                out_loads_q  <= skid_loads_q;
                skid_valid_q <= 1'b0;
`ifdef ALU_CARRY_EN
                out_carry_q  <= skid_carry_q;
`endif
            end else if (w_accept && (!out_valid_q || w_xfer)) begin
                out_valid_q <= 1'b1;
                out_c_q     <= w_res;
                out_flags_q <= w_flags;
                out_loads_q <= in_loads;
`ifdef ALU_CARRY_EN
                out_carry_q <= w_carry;
`endif
            end else if (w_accept) begin
                skid_valid_q <= 1'b1;
                skid_c_q     <= w_res;
                skid_flags_q <= w_flags;
                skid_loads_q <= in_loads;
`ifdef ALU_CARRY_EN
                skid_carry_q <= w_carry;
`endif
            end else if (w_xfer) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_c     = out_c_q;
    assign out_flags = out_flags_q;
    assign status    = status_q;
`ifdef ALU_CARRY_EN
    assign out_carry = out_carry_q;
    assign status_c  = status_c_q;
`endif

endmodule

`default_nettype wire
